// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath: default widths, MAC state encoding
// and the output saturation limits used by every stage that narrows to OW bits.
package nn_pkg;

    localparam int DEF_N    = 10;   // weight/input pairs per neuron
    localparam int DEF_WW   = 10;   // weight width (signed)
    localparam int DEF_XW   = 10;   // activation width (signed)
    localparam int DEF_ACCW = 24;   // accumulator width, >= WW+XW+clog2(N+1)
    localparam int OW       = 16;   // saturated output width (signed)

    // Most positive and most negative OW-bit two's complement values.
    localparam logic signed [OW-1:0] SAT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] SAT_MIN = {1'b1, {(OW-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } mac_state_t;

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed saturation from a wide IW-bit value down to OW bits.
// Values beyond the OW-bit range clamp to SAT_MAX / SAT_MIN instead of wrapping.
module sat_clamp
    import nn_pkg::*;
#(
    parameter int IW = DEF_ACCW
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout
);

    // Limits sign-extended into the input domain so the compare is exact.
    localparam logic signed [IW-1:0] HI = IW'(SAT_MAX);
    localparam logic signed [IW-1:0] LO = IW'(SAT_MIN);

    // Clamp to the representable output range, otherwise pass the low bits through.
    always_comb begin
        dout = din[OW-1:0];
        if (din > HI) begin
            dout = SAT_MAX;
        end else if (din < LO) begin
            dout = SAT_MIN;
        end
    end

endmodule

// File: rtl/weighted_sum_mac.sv
// Sequential multiply-accumulate for one neuron: y = sat(bias + sum(w[i]*x[i])).
// Operands are snapshotted on Start so the upstream weight bus may move on while
// the N products are accumulated, one per clock.
module weighted_sum_mac
    import nn_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int WW   = DEF_WW,
    parameter int XW   = DEF_XW,
    parameter int ACCW = DEF_ACCW
) (
    input  logic                 Clock,
    input  logic                 Rst,      // asynchronous, active low
    input  logic                 Start,
    input  logic signed [WW-1:0] W_in [N],
    input  logic signed [XW-1:0] X_in [N],
    input  logic signed [WW-1:0] Bias,
    output logic                 Busy,
    output logic                 Done,
    output logic signed [OW-1:0] Y
);

    // Index must still be at least one bit wide when N=1.
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int PW   = WW + XW;

    mac_state_t              state_reg, state_next;
    logic [IDXW-1:0]         index_reg, index_next;
    logic signed [ACCW-1:0]  acc_reg,   acc_next;
    logic                    busy_reg,  busy_next;
    logic                    done_reg,  done_next;
    logic signed [OW-1:0]    y_reg,     y_next;
    logic                    load_snap;

    logic signed [WW-1:0]    w_snap_reg [N];
    logic signed [XW-1:0]    x_snap_reg [N];

    logic signed [PW-1:0]    prod;
    logic signed [ACCW-1:0]  acc_sum;
    logic signed [OW-1:0]    y_sat;
    logic                    last_term;

    // Full-precision product of the current pair, accumulated after sign extension.
    assign prod      = w_snap_reg[index_reg] * x_snap_reg[index_reg];
    assign acc_sum   = acc_reg + ACCW'(prod);
    assign last_term = (index_reg == IDXW'(N - 1));

    sat_clamp #(
        .IW (ACCW)
    ) u_sat (
        .din  (acc_sum),
        .dout (y_sat)
    );

    // Snapshot registers: each weight/activation pair latched only when a job launches.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_snap
            // Capture pair gi on an accepted Start; hold otherwise.
            always_ff @(posedge Clock or negedge Rst) begin
                if (!Rst) begin
                    w_snap_reg[gi] <= '0;
                    x_snap_reg[gi] <= '0;
                end else if (load_snap) begin
                    w_snap_reg[gi] <= W_in[gi];
                    x_snap_reg[gi] <= X_in[gi];
                end
            end
        end
    endgenerate

    // Next-state and datapath control; Start is only honoured in IDLE.
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        acc_next   = acc_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        y_next     = y_reg;
        load_snap  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    load_snap  = 1'b1;
                    acc_next   = ACCW'(Bias);
                    index_next = '0;
                    busy_next  = 1'b1;
                    state_next = ACC;
                end
            end
            ACC: begin
                acc_next = acc_sum;
                if (last_term) begin
                    y_next     = y_sat;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    index_next = '0;
                    state_next = IDLE;
                end else begin
                    index_next = index_reg + IDXW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                index_next = '0;
            end
        endcase
    end

    // State, accumulator and output registers; reset aborts any job in flight.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state_reg <= IDLE;
            index_reg <= '0;
            acc_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            acc_reg   <= acc_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            y_reg     <= y_next;
        end
    end

    assign Busy = busy_reg;
    assign Done = done_reg;
    assign Y    = y_reg;

endmodule

// File: tb/tb_weighted_sum_mac.sv
// Self-checking bench for weighted_sum_mac: directed and random jobs compared
// against a plain-arithmetic model of bias + sum(w*x) with 16-bit saturation.
module tb_weighted_sum_mac;

    localparam int N = 10;

    logic              Clock;
    logic              Rst;
    logic              Start;
    logic signed [9:0] w_in [N];
    logic signed [9:0] x_in [N];
    logic signed [9:0] bias_in;
    logic              Busy;
    logic              Done;
    logic signed [15:0] Y;

    int w_arr [N];
    int x_arr [N];
    int b_val;

    int total_cnt = 0;
    int pass_cnt  = 0;

    weighted_sum_mac dut (
        .Clock (Clock),
        .Rst   (Rst),
        .Start (Start),
        .W_in  (w_in),
        .X_in  (x_in),
        .Bias  (bias_in),
        .Busy  (Busy),
        .Done  (Done),
        .Y     (Y)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: exact integer sum, then clamp to the signed 16-bit range.
    function automatic int model_y();
        longint s;
        s = longint'(b_val);
        for (int i = 0; i < N; i++) s += longint'(w_arr[i]) * longint'(x_arr[i]);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            w_in[i] = 10'(w_arr[i]);
            x_in[i] = 10'(x_arr[i]);
        end
        bias_in = 10'(b_val);
    endtask

    task automatic scramble();
        for (int i = 0; i < N; i++) begin
            w_in[i] = 10'($urandom);
            x_in[i] = 10'($urandom);
        end
        bias_in = 10'($urandom);
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < N; i++) begin
            w_arr[i] = int'($urandom_range(0, 1023)) - 512;
            x_arr[i] = int'($urandom_range(0, 1023)) - 512;
        end
        b_val = int'($urandom_range(0, 1023)) - 512;
    endtask

    // Launch one job from IDLE and follow it to Done.
    // hold: keep Start high throughout; repulse: pulse Start and disturb W_in mid-job;
    // scr: disturb all inputs every ACC cycle; tail: check the cycle after Done.
    task automatic run_op(input string tag, input int exp, input bit hold,
                          input bit repulse, input bit scr, input bit tail);
        apply();
        Start = 1'b1;
        step();
        if (!hold) Start = 1'b0;
        for (int c = 1; c <= N; c++) begin
            step();
            if (c < N) begin
                check({tag, "_busy"}, 32'(Busy), 1);
                check({tag, "_done_early"}, 32'(Done), 0);
            end else begin
                check({tag, "_done"}, 32'(Done), 1);
                check({tag, "_busy_end"}, 32'(Busy), 0);
                check({tag, "_y"}, Y, exp);
            end
            if (repulse && c == 2) Start = 1'b1;
            if (repulse && c == 3) begin
                Start = 1'b0;
                for (int i = 0; i < N; i++) w_in[i] = 10'($urandom);
            end
            if (scr && c < N) scramble();
        end
        $display("op %s: y=%0d expected %0d", tag, Y, exp);
        if (tail) begin
            step();
            check({tag, "_done_pulse"}, 32'(Done), 0);
            check({tag, "_y_hold"}, Y, exp);
        end
    endtask

    initial begin
        Rst   = 1'b0;
        Start = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_arr[i] = 0;
            x_arr[i] = 0;
        end
        b_val = 0;
        apply();
        step();
        step();
        check("rst_y", Y, 0);
        check("rst_done", 32'(Done), 0);
        check("rst_busy", 32'(Busy), 0);
        Rst = 1'b1;
        step();

        // All ones, zero bias.
        for (int i = 0; i < N; i++) begin
            w_arr[i] = 1;
            x_arr[i] = 1;
        end
        b_val = 0;
        run_op("ones", 10, 1'b0, 1'b0, 1'b0, 1'b1);

        // w[i]=i-5, x=3, bias=-7.
        for (int i = 0; i < N; i++) begin
            w_arr[i] = i - 5;
            x_arr[i] = 3;
        end
        b_val = -7;
        run_op("ramp", -22, 1'b0, 1'b0, 1'b0, 1'b1);

        // Positive saturation.
        for (int i = 0; i < N; i++) begin
            w_arr[i] = 511;
            x_arr[i] = 511;
        end
        b_val = 511;
        run_op("sat_pos", 32767, 1'b0, 1'b0, 1'b0, 1'b1);

        // Negative saturation.
        for (int i = 0; i < N; i++) begin
            w_arr[i] = -512;
            x_arr[i] = 511;
        end
        b_val = 0;
        run_op("sat_neg", -32768, 1'b0, 1'b0, 1'b0, 1'b1);

        // Start re-pulsed mid-job and W_in disturbed: ignored. Next Start in the Done cycle.
        randomize_ops();
        run_op("repulse", model_y(), 1'b0, 1'b1, 1'b0, 1'b0);
        randomize_ops();
        run_op("done_cycle_start", model_y(), 1'b0, 1'b0, 1'b0, 1'b1);

        // Start held continuously across two jobs.
        randomize_ops();
        run_op("held_a", model_y(), 1'b1, 1'b0, 1'b0, 1'b0);
        randomize_ops();
        run_op("held_b", model_y(), 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a job: immediate abort, Y lost, no Done.
        for (int i = 0; i < N; i++) begin
            w_arr[i] = 1;
            x_arr[i] = 1;
        end
        b_val = 0;
        apply();
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int c = 1; c <= 4; c++) step();
        #2;
        Rst = 1'b0;
        #1;
        check("abort_busy", 32'(Busy), 0);
        check("abort_done", 32'(Done), 0);
        check("abort_y", Y, 0);
        begin
            int done_seen;
            done_seen = 0;
            for (int c = 0; c < 8; c++) begin
                step();
                if (Done) done_seen++;
            end
            check("abort_no_done", done_seen, 0);
        end
        Rst = 1'b1;
        step();
        run_op("after_abort", 10, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random jobs with the upstream bus moving during accumulation.
        for (int t = 0; t < 6; t++) begin
            randomize_ops();
            run_op($sformatf("rand%0d", t), model_y(), 1'b0, 1'b0, 1'b1, 1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global time bound so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule
